// File: rtl/fetch_btb_predictor.sv
// -----------------------------------------------------------------------------
// fetch_btb_predictor
//   Set-associative branch target buffer for the instruction-fetch stage.
//   Each entry holds valid, tag, target and a saturating direction counter.
//   Sets with two ways keep one LRU bit, which records the least-recently-used
//   way. Lookups are combinational and zero-latency. Resolved-branch updates
//   arrive one per cycle and are written on clk.
//
// Parameters
//   ADDR_W  PC/target width
//   SETS    number of sets (power of two, >= 2)
//   WAYS    associativity (1 or 2)
//   CTR_W   direction counter width (1..3)
//
// Ports
//   clk, rst      clock, synchronous active-high reset (clears valid/LRU/ctr)
//   flush         invalidate all entries at the next edge (update discarded)
//   lk_pc         fetch PC looked up this cycle
//   lk_hit        valid matching entry found
//   lk_taken      hit and counter MSB set
//   lk_target     predicted target, 0 on miss
//   upd_valid     resolved-branch update strobe
//   upd_pc        PC of the resolved branch
//   upd_taken     actual outcome
//   upd_target    actual taken target
//
// Build option
//   BTB_UPDATE_BYPASS_EN  forward a same-cycle update to the same PC onto the
//                         lookup outputs. When it is undefined, a lookup sees
//                         the pre-update table contents.
// -----------------------------------------------------------------------------
module fetch_btb_predictor #(
  parameter int ADDR_W = 32,
  parameter int SETS   = 4,
  parameter int WAYS   = 2,
  parameter int CTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [ADDR_W-1:0] lk_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);

  logic [WAYS-1:0]   valid_q  [SETS];
  logic [TAG_W-1:0]  tag_q    [SETS][WAYS];
  logic [ADDR_W-1:0] target_q [SETS][WAYS];
  logic [CTR_W-1:0]  ctr_q    [SETS][WAYS];
  logic              lru_q    [SETS];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

  // Byte-offset bits never take part in indexing or tagging.
  logic unused;
  assign unused = ^{lk_pc[1:0], upd_pc[1:0]};

  // ---------------------------------------------------------------- lookup
  logic             lk_found;
  logic [WAY_W-1:0] lk_way;

  always_comb begin
    lk_found = 1'b0;
    lk_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!lk_found && valid_q[lk_idx][WAY_W'(w)] &&
          tag_q[lk_idx][WAY_W'(w)] == lk_tag) begin
        lk_found = 1'b1;
        lk_way   = WAY_W'(w);
      end
    end
  end

  // ---------------------------------------------------------------- update
  logic             upd_hit, inv_found, upd_write;
  logic [WAY_W-1:0] hit_way, inv_way, victim_way, sel_way;
  logic [CTR_W-1:0] ctr_cur, ctr_next;
  logic [ADDR_W-1:0] tgt_next;

  always_comb begin
    upd_hit   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!upd_hit && valid_q[upd_idx][WAY_W'(w)] &&
          tag_q[upd_idx][WAY_W'(w)] == upd_tag) begin
        upd_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[upd_idx][WAY_W'(w)]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end

    if (inv_found)      victim_way = inv_way;
    else if (WAYS == 2) victim_way = WAY_W'(lru_q[upd_idx]);
    else                victim_way = '0;

    sel_way = upd_hit ? hit_way : victim_way;
    ctr_cur = ctr_q[upd_idx][hit_way];

    if (!upd_hit)
      ctr_next = CTR_INIT;
    else if (upd_taken)
      ctr_next = (ctr_cur == '1) ? ctr_cur : ctr_cur + CTR_W'(1);
    else
      ctr_next = (ctr_cur == '0) ? ctr_cur : ctr_cur - CTR_W'(1);

    tgt_next  = upd_taken ? upd_target : target_q[upd_idx][hit_way];
    // A not-taken miss leaves the table untouched.
    upd_write = upd_valid && (upd_hit || upd_taken);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        lru_q[s]   <= 1'b0;
        for (int unsigned w = 0; w < WAYS; w++)
          ctr_q[s][w] <= '0;
      end
    end else if (flush) begin
      for (int unsigned s = 0; s < SETS; s++)
        valid_q[s] <= '0;
    end else if (upd_write) begin
      valid_q[upd_idx][sel_way]  <= 1'b1;
      tag_q[upd_idx][sel_way]    <= upd_tag;
      target_q[upd_idx][sel_way] <= tgt_next;
      ctr_q[upd_idx][sel_way]    <= ctr_next;
      // The way just written becomes MRU, so the other way is now LRU.
      if (WAYS == 2)
        lru_q[upd_idx] <= ~sel_way[0];
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    lk_hit    = lk_found;
    lk_taken  = lk_found & ctr_q[lk_idx][lk_way][CTR_W-1];
    lk_target = lk_found ? target_q[lk_idx][lk_way] : '0;
`ifdef BTB_UPDATE_BYPASS_EN
    if (upd_write && !flush && !rst && upd_idx == lk_idx && upd_tag == lk_tag) begin
      lk_hit    = 1'b1;
      lk_taken  = ctr_next[CTR_W-1];
      lk_target = tgt_next;
    end
`endif
  end

endmodule

// File: tb/tb_fetch_btb_predictor.sv
module tb_fetch_btb_predictor;

  logic        clk = 1'b0;
  logic        rst, flush, upd_valid, upd_taken;
  logic [31:0] lk_pc, upd_pc, upd_target, lk_target;
  logic        lk_hit, lk_taken;
  logic        lk_req;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_btb_predictor #(.ADDR_W(32), .SETS(4), .WAYS(2), .CTR_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_target(lk_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target)
  );

  // Monitor: a lookup request is the "output valid"; compare mid-cycle.
  always @(negedge clk) begin
    if (lk_req) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: lookup presented with no expected entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (lk_hit !== e.hit || lk_taken !== e.taken || lk_target !== e.target) begin
          errors++;
          $display("FAIL %s: got hit=%b taken=%b target=%h, expected hit=%b taken=%b target=%h",
                   e.name, lk_hit, lk_taken, lk_target, e.hit, e.taken, e.target);
        end
      end
    end
  end

  // One clock of stimulus; optional lookup with its expectation pushed.
  task automatic step(input logic r, input logic f,
                      input logic uv, input logic [31:0] up, input logic ut,
                      input logic [31:0] utg,
                      input logic req, input logic [31:0] lpc,
                      input logic eh, input logic et, input logic [31:0] etg,
                      input string nm);
    exp_t e;
    rst = r; flush = f;
    upd_valid = uv; upd_pc = up; upd_taken = ut; upd_target = utg;
    lk_req = req; lk_pc = lpc;
    if (req) begin
      e.hit = eh; e.taken = et; e.target = etg; e.name = nm;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; upd_valid = 1'b0; lk_req = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input logic eh, input logic et,
                      input logic [31:0] etg, input string nm);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, pc, eh, et, etg, nm);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    step(1'b0, 1'b0, 1'b1, pc, t, tg, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; lk_pc = '0; lk_req = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "");

    look(32'h40, 1'b0, 1'b0, 32'h0, "reset_miss");

    // Allocate: weakly taken (10)
    upd(32'h40, 1'b1, 32'h100);
    look(32'h40, 1'b1, 1'b1, 32'h100, "alloc_hit");
    look(32'h43, 1'b1, 1'b1, 32'h100, "low_bits_ignored");
    look(32'h44, 1'b0, 1'b0, 32'h0,   "other_set_miss");

    // Down-count and saturate at 00; not-taken keeps old target
    upd(32'h40, 1'b0, 32'hDEAD);
    look(32'h40, 1'b1, 1'b0, 32'h100, "ctr_01");
    upd(32'h40, 1'b0, 32'hDEAD);
    look(32'h40, 1'b1, 1'b0, 32'h100, "ctr_00");
    upd(32'h40, 1'b0, 32'hDEAD);
    look(32'h40, 1'b1, 1'b0, 32'h100, "ctr_sat_low");

    // Up-count to 10, then saturate at 11
    upd(32'h40, 1'b1, 32'h100);
    look(32'h40, 1'b1, 1'b0, 32'h100, "ctr_up_01");
    upd(32'h40, 1'b1, 32'h100);
    look(32'h40, 1'b1, 1'b1, 32'h100, "ctr_up_10");
    for (int i = 0; i < 4; i++) upd(32'h40, 1'b1, 32'h100);
    look(32'h40, 1'b1, 1'b1, 32'h100, "ctr_11");
    upd(32'h40, 1'b0, 32'h0);
    look(32'h40, 1'b1, 1'b1, 32'h100, "ctr_sat_high_10");
    upd(32'h40, 1'b0, 32'h0);
    look(32'h40, 1'b1, 1'b0, 32'h100, "ctr_down_01");

    // Replacement in set 0: 0x80 becomes LRU and is evicted by 0xC0
    upd(32'h80, 1'b1, 32'h180);
    upd(32'h40, 1'b1, 32'h100);
    upd(32'hC0, 1'b1, 32'h1C0);
    look(32'h80, 1'b0, 1'b0, 32'h0,   "lru_evicted");
    look(32'h40, 1'b1, 1'b1, 32'h100, "lru_kept_40");
    look(32'hC0, 1'b1, 1'b1, 32'h1C0, "lru_new_c0");

    // Not-taken miss: no allocation, no forwarding either
    step(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h999, 1'b1, 32'h80,
         1'b0, 1'b0, 32'h0, "nt_miss_same_cycle");
    look(32'h80, 1'b0, 1'b0, 32'h0, "nt_miss_no_alloc");

    // Same-cycle lookup + update on 0x40 (counter 10 -> 11)
`ifdef BTB_UPDATE_BYPASS_EN
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h40,
         1'b1, 1'b1, 32'h200, "same_cycle_bypass");
`else
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h40,
         1'b1, 1'b1, 32'h100, "same_cycle_old");
`endif
    look(32'h40, 1'b1, 1'b1, 32'h200, "same_cycle_next");

    // Flush with a concurrent update: update dropped, everything misses
    step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h280, 1'b1, 32'h40,
         1'b1, 1'b1, 32'h200, "flush_cycle_pre");
    look(32'h80, 1'b0, 1'b0, 32'h0, "flush_80");
    look(32'h40, 1'b0, 1'b0, 32'h0, "flush_40");
    look(32'hC0, 1'b0, 1'b0, 32'h0, "flush_c0");

    // Reset with a concurrent update: nothing written
    upd(32'h40, 1'b1, 32'h300);
    look(32'h40, 1'b1, 1'b1, 32'h300, "realloc_40");
    step(1'b1, 1'b0, 1'b1, 32'h44, 1'b1, 32'h400, 1'b1, 32'h40,
         1'b1, 1'b1, 32'h300, "rst_cycle_pre");
    look(32'h44, 1'b0, 1'b0, 32'h0, "rst_no_write");
    look(32'h40, 1'b0, 1'b0, 32'h0, "rst_cleared");
    upd(32'h44, 1'b1, 32'h400);
    look(32'h44, 1'b1, 1'b1, 32'h400, "post_rst_alloc");

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_btb_predictor.md
Name: fetch_btb_predictor

Overview:
- Parametrised set-associative branch target buffer with per-entry saturating direction counters for the instruction-fetch stage.
- Fetch presents the current PC and receives a combinational same-cycle prediction: hit, predicted-taken and target.
- Decode presents resolved branch outcomes through a one-per-cycle update port; entries are allocated or trained on clk.
- Successor to the fixed 8-entry, 1-bit-taken predictor: configurable depth, associativity, counter width, LRU replacement and flush.

Parameters:
- ADDR_W, 32, PC and target width in bits.
- SETS, 4, number of sets; power of two, at least 2.
- WAYS, 2, associativity; 1 or 2.
- CTR_W, 2, saturating counter width; 1 to 3.
- Derived: IDX_W = log2(SETS); TAG_W = ADDR_W-IDX_W-2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronously invalidate all entries.
- lk_pc  in  ADDR_W  fetch PC to look up.
- lk_hit  out  1  valid entry with matching tag found.
- lk_taken  out  1  predict taken (lk_hit and counter MSB set).
- lk_target  out  ADDR_W  predicted target; 0 when lk_hit=0.
- upd_valid  in  1  resolved branch update strobe, already gated by the pipeline-stall/PC-write enable.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_W  actual taken target.

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored.
- Lookup is purely combinational from lk_pc and table state, with zero latency.
  - If multiple ways match, which is illegal by construction, the lowest-numbered way wins.
  - lk_taken = lk_hit & ctr[CTR_W-1].
- Update hit (tag match in the set at upd_pc's index):
  - Write upd_target when upd_taken=1; keep the old target when upd_taken=0.
  - Counter saturating +1 on taken, -1 on not-taken; saturates at all-ones and at 0, with no wrap.
  - Mark that way most-recently-used.
- Update miss, upd_taken=1:
  - Allocate. Victim is the first invalid way (lowest index); otherwise the LRU way.
  - Write valid=1, tag and target. Counter initialises to weakly-taken: MSB=1, other bits 0 (CTR_W=1 gives 1).
  - Mark the victim MRU.
- Update miss, upd_taken=0: no state change.
- LRU state is one bit per set, changed only by updates; lookups never touch it. With WAYS=1, LRU logic is absent.
- Lookup and update in the same cycle see pre-update contents, with no forwarding unless the optional feature is compiled in. The written state is visible on the next cycle.
- flush=1: all valid bits clear at the next posedge. An update in the same cycle is discarded. Counters, tags and targets are don't-care.
- rst=1: valid bits, LRU bits and counters clear to 0. Outputs then read lk_hit=0, lk_taken=0, lk_target=0.
- rst asserted mid-operation overrides flush and upd_valid in that cycle.
- Priority: rst > flush > upd_valid.
- No X propagation: lk_target is driven to 0 on miss.

Optional Feature:
- Macro BTB_UPDATE_BYPASS_EN.
- Defined: when upd_valid=1, index(upd_pc)=index(lk_pc) and tag(upd_pc)=tag(lk_pc), the lookup outputs reflect the post-update entry in the same cycle:
  - lk_hit=1 if the update hits or allocates.
  - lk_target and the counter MSB take their new values.
- Not forwarded: when the update is a miss with upd_taken=0, lookup is unaffected.
- Bypass is suppressed when flush or rst is asserted.
- Undefined: the same-cycle lookup returns the old contents, as in the base behaviour.

Test Plan:
- Reset, then lk_pc=0x0000_0040 -> lk_hit=0, lk_taken=0, lk_target=0.
- upd(pc=0x40, taken=1, target=0x100); next cycle lk_pc=0x40 -> hit=1, taken=1, target=0x100 (counter 2'b10).
- Counter saturation (CTR_W=2) on pc=0x40: two not-taken updates -> taken=0 (counter 00); a third not-taken keeps 00; then two taken updates -> counter 10, taken=1; four more taken -> counter 11, with no wrap.
- Replacement (SETS=4, WAYS=2): allocate pc 0x40, 0x80, then update 0x40 (0x40 is now MRU); allocate 0xC0, all at index 0 -> 0x80 evicted; lookup 0x80 misses while 0x40 and 0xC0 hit.
- Same-cycle lookup+update on pc=0x40 with new target 0x200 -> base build shows target 0x100 that cycle and 0x200 the next; with BTB_UPDATE_BYPASS_EN it shows 0x200 in the same cycle.
- flush=1 together with upd_valid (pc=0x80) -> next cycle all lookups miss, including 0x80; rst held with upd_valid=1 -> no entry written.
